// File: rtl/mcl_to_axil_master_pkg.sv
// Shared definitions for the MCL-to-AXI-Lite initiator: op codes, AXI response codes
// and the 80-bit command/response packet layouts.
package mcl_to_axil_master_pkg;

    localparam int mcl_width_lp = 80;

    localparam logic [3:0] op_wr_c      = 4'h1;
    localparam logic [3:0] op_rd_c      = 4'h2;
    localparam logic [3:0] op_wr_ack_c  = 4'h8;
    localparam logic [3:0] op_rd_data_c = 4'h9;

    localparam logic [1:0] axi_okay_c   = 2'b00;
    localparam logic [1:0] axi_exokay_c = 2'b01;
    localparam logic [1:0] axi_slverr_c = 2'b10;
    localparam logic [1:0] axi_decerr_c = 2'b11;

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  wstrb;
        logic [7:0]  tag;
        logic [31:0] addr;
        logic [31:0] data;
    } mcl_cmd_s;

    typedef struct packed {
        logic [3:0]  op;
        logic [1:0]  resp;
        logic [1:0]  rsvd;
        logic [7:0]  tag;
        logic [31:0] addr;
        logic [31:0] data;
    } mcl_resp_s;

    function automatic mcl_resp_s make_resp(input logic [3:0] op, input logic [1:0] resp,
                                            input logic [7:0] tag, input logic [31:0] addr,
                                            input logic [31:0] data);
        make_resp = '{op: op, resp: resp, rsvd: 2'b00, tag: tag, addr: addr, data: data};
    endfunction

endpackage

// File: rtl/mcl_to_axil_master_if.sv
// AXI-Lite (32-bit address/data) channel bundle between the initiator and a slave.
interface mcl_to_axil_master_if;

    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/mcl_to_axil_master_timeout_counter.sv
// Response-wait watchdog: cleared by load, counts while enabled, flags the last allowed cycle.
module mcl_axil_timeout_counter #(
    parameter int timeout_p = 1024
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int cnt_w_lp = (timeout_p > 0) ? $clog2(timeout_p + 1) : 1;
    localparam logic [cnt_w_lp-1:0] last_lp = cnt_w_lp'((timeout_p > 0) ? timeout_p - 1 : 0);

    logic [cnt_w_lp-1:0] count_r;

    always_ff @(posedge clk_i) begin
        if (reset_i || load_i) begin
            count_r <= '0;
        end else if (en_i) begin
            count_r <= count_r + cnt_w_lp'(1);
        end
    end

    // Expiry fires on the timeout_p-th enabled cycle; timeout_p == 0 never expires.
    assign expire_o = (timeout_p != 0) && en_i && (count_r == last_lp);

endmodule

// File: rtl/mcl_to_axil_master.sv
// MCL command -> single AXI-Lite read/write -> MCL response; one transaction in flight.
module mcl_to_axil_master
    import mcl_to_axil_master_pkg::*;
#(
    parameter int timeout_p = 1024
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    mcl_v_i,
    input  logic [mcl_width_lp-1:0] mcl_data_i,
    output logic                    mcl_yumi_o,
    output logic                    mcl_v_o,
    output logic [mcl_width_lp-1:0] mcl_data_o,
    input  logic                    mcl_ready_i,
    mcl_to_axil_master_if.master    m_axil
);

    localparam logic [2:0] idle_s    = 3'd0;
    localparam logic [2:0] wr_aw_w_s = 3'd1;
    localparam logic [2:0] wr_b_s    = 3'd2;
    localparam logic [2:0] rd_ar_s   = 3'd3;
    localparam logic [2:0] rd_r_s    = 3'd4;
    localparam logic [2:0] send_s    = 3'd5;

    logic [2:0] state_r;
    mcl_cmd_s   cmd_in;
    mcl_cmd_s   cmd_r;
    mcl_resp_s  resp_r;
    logic       mcl_v_r;
    logic       drop_r;
    logic       awvalid_r, wvalid_r, bready_r, arvalid_r, rready_r;
    logic       wait_st, expire, aw_done, w_done, late_beat;

    assign cmd_in     = mcl_data_i;
    assign mcl_yumi_o = !reset_i && (state_r == idle_s) && !drop_r && mcl_v_i;
    assign mcl_v_o    = mcl_v_r;
    assign mcl_data_o = resp_r;

    assign m_axil.awvalid = awvalid_r;
    assign m_axil.awaddr  = cmd_r.addr;
    assign m_axil.wvalid  = wvalid_r;
    assign m_axil.wdata   = cmd_r.data;
    assign m_axil.wstrb   = cmd_r.wstrb;
    assign m_axil.bready  = bready_r;
    assign m_axil.arvalid = arvalid_r;
    assign m_axil.araddr  = cmd_r.addr;
    assign m_axil.rready  = rready_r;

    assign wait_st   = (state_r == wr_b_s) || (state_r == rd_r_s);
    assign aw_done   = !awvalid_r || m_axil.awready;
    assign w_done    = !wvalid_r || m_axil.wready;
    assign late_beat = drop_r && ((m_axil.bvalid && bready_r) || (m_axil.rvalid && rready_r));

    mcl_axil_timeout_counter #(.timeout_p(timeout_p)) timeout_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (!wait_st),
        .en_i    (wait_st),
        .expire_o(expire)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r   <= idle_s;
            cmd_r     <= '0;
            resp_r    <= '0;
            mcl_v_r   <= 1'b0;
            drop_r    <= 1'b0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
        end else begin
            // A timed-out transaction keeps its ready high until the straggling beat is swallowed.
            if (late_beat) begin
                drop_r   <= 1'b0;
                bready_r <= 1'b0;
                rready_r <= 1'b0;
            end
            case (state_r)
                idle_s: begin
                    if (mcl_yumi_o) begin
                        cmd_r <= cmd_in;
                        if (cmd_in.op == op_wr_c) begin
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                            state_r   <= wr_aw_w_s;
                        end else if (cmd_in.op == op_rd_c) begin
                            arvalid_r <= 1'b1;
                            state_r   <= rd_ar_s;
                        end else begin
                            resp_r  <= make_resp(cmd_in.op, axi_slverr_c, cmd_in.tag, cmd_in.addr, '0);
                            mcl_v_r <= 1'b1;
                            state_r <= send_s;
                        end
                    end
                end
                wr_aw_w_s: begin
                    if (m_axil.awready) awvalid_r <= 1'b0;
                    if (m_axil.wready)  wvalid_r  <= 1'b0;
                    if (aw_done && w_done) begin
                        bready_r <= 1'b1;
                        state_r  <= wr_b_s;
                    end
                end
                wr_b_s: begin
                    if (m_axil.bvalid) begin
                        bready_r <= 1'b0;
                        resp_r   <= make_resp(op_wr_ack_c, m_axil.bresp, cmd_r.tag, cmd_r.addr, '0);
                        mcl_v_r  <= 1'b1;
                        state_r  <= send_s;
                    end else if (expire) begin
                        drop_r  <= 1'b1;
                        resp_r  <= make_resp(op_wr_ack_c, axi_decerr_c, cmd_r.tag, cmd_r.addr, '0);
                        mcl_v_r <= 1'b1;
                        state_r <= send_s;
                    end
                end
                rd_ar_s: begin
                    if (m_axil.arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= rd_r_s;
                    end
                end
                rd_r_s: begin
                    if (m_axil.rvalid) begin
                        rready_r <= 1'b0;
                        resp_r   <= make_resp(op_rd_data_c, m_axil.rresp, cmd_r.tag, cmd_r.addr,
                                              m_axil.rdata);
                        mcl_v_r  <= 1'b1;
                        state_r  <= send_s;
                    end else if (expire) begin
                        drop_r  <= 1'b1;
                        resp_r  <= make_resp(op_rd_data_c, axi_decerr_c, cmd_r.tag, cmd_r.addr, '0);
                        mcl_v_r <= 1'b1;
                        state_r <= send_s;
                    end
                end
                send_s: begin
                    if (mcl_ready_i) begin
                        mcl_v_r <= 1'b0;
                        state_r <= idle_s;
                    end
                end
                default: state_r <= idle_s;
            endcase
        end
    end

endmodule

// File: tb/tb_mcl_to_axil_master.sv
// Scoreboard bench: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_mcl_to_axil_master;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        mcl_v_i;
    logic [79:0] mcl_data_i;
    logic        mcl_yumi_o;
    logic        mcl_v_o;
    logic [79:0] mcl_data_o;
    logic        mcl_ready_i;

    mcl_to_axil_master_if axi ();

    mcl_to_axil_master #(.timeout_p(8)) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .mcl_v_i    (mcl_v_i),
        .mcl_data_i (mcl_data_i),
        .mcl_yumi_o (mcl_yumi_o),
        .mcl_v_o    (mcl_v_o),
        .mcl_data_o (mcl_data_o),
        .mcl_ready_i(mcl_ready_i),
        .m_axil     (axi.master)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [79:0] exp_q[$];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave knobs and observations
    int          aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
    bit          b_hold = 0, r_hold = 0;
    logic [1:0]  b_resp_k = 2'b00, r_resp_k = 2'b00;
    logic [31:0] rd_data_k = '0;
    int          aw_hs_cyc = 0, ar_hs_cyc = 0;
    logic [31:0] seen_awaddr = '0, seen_wdata = '0, seen_araddr = '0;
    logic [3:0]  seen_wstrb = '0;
    int          aw_only_cycles = 0, any_valid_cycles = 0;

    // Reactive AXI-Lite slave: handshakes seen at negedge, outputs updated just after posedge.
    initial begin
        bit hs_aw, hs_w, hs_b, hs_ar, hs_r, rst_s;
        bit aw_got, w_got, b_owed, r_owed;
        int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        aw_got = 0; w_got = 0; b_owed = 0; r_owed = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        axi.awready = 0; axi.wready = 0; axi.arready = 0;
        axi.bvalid = 0; axi.bresp = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
        forever begin
            @(negedge clk);
            rst_s = reset_i;
            hs_aw = axi.awvalid && axi.awready;
            hs_w  = axi.wvalid && axi.wready;
            hs_b  = axi.bvalid && axi.bready;
            hs_ar = axi.arvalid && axi.arready;
            hs_r  = axi.rvalid && axi.rready;
            if (hs_aw) begin seen_awaddr = axi.awaddr; aw_hs_cyc = cyc; end
            if (hs_w)  begin seen_wdata = axi.wdata; seen_wstrb = axi.wstrb; end
            if (hs_ar) begin seen_araddr = axi.araddr; ar_hs_cyc = cyc; end
            if (axi.awvalid && !axi.wvalid) aw_only_cycles++;
            if (axi.awvalid || axi.wvalid || axi.arvalid) any_valid_cycles++;
            @(posedge clk);
            #1;
            if (rst_s) begin
                aw_got = 0; w_got = 0; b_owed = 0; r_owed = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                axi.awready = 0; axi.wready = 0; axi.arready = 0;
                axi.bvalid = 0; axi.rvalid = 0;
            end else begin
                if (hs_aw) aw_got = 1;
                if (hs_w)  w_got = 1;
                if (hs_b)  b_owed = 0;
                if (hs_r)  r_owed = 0;
                if (aw_got && w_got) begin b_owed = 1; b_cnt = 0; aw_got = 0; w_got = 0; end
                if (hs_ar) begin r_owed = 1; r_cnt = 0; end
                if (axi.awvalid) begin axi.awready = (aw_cnt >= aw_wait); aw_cnt++; end
                else begin axi.awready = 0; aw_cnt = 0; end
                if (axi.wvalid) begin axi.wready = (w_cnt >= w_wait); w_cnt++; end
                else begin axi.wready = 0; w_cnt = 0; end
                if (axi.arvalid) begin axi.arready = (ar_cnt >= ar_wait); ar_cnt++; end
                else begin axi.arready = 0; ar_cnt = 0; end
                axi.bvalid = b_owed && !b_hold && (b_cnt >= b_wait);
                axi.bresp  = b_resp_k;
                if (b_owed) b_cnt++;
                axi.rvalid = r_owed && !r_hold && (r_cnt >= r_wait);
                axi.rdata  = rd_data_k;
                axi.rresp  = r_resp_k;
                if (r_owed) r_cnt++;
            end
        end
    end

    // Response monitor
    int v_rise_cyc = 0, resp_hs_cyc = 0;
    initial begin
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (mcl_v_o && !prev_v) v_rise_cyc = cyc;
            prev_v = mcl_v_o;
            if (!reset_i && mcl_v_o && mcl_ready_i) begin
                resp_hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_resp: got %h expected none", mcl_data_o);
                end else begin
                    chk("resp", mcl_data_o, exp_q.pop_front());
                end
            end
        end
    end

    int accept_cyc = 0;

    task automatic issue(input logic [79:0] cmd, input logic [79:0] exp, input bit want_resp);
        int n;
        if (want_resp) exp_q.push_back(exp);
        mcl_v_i = 1'b1;
        mcl_data_i = cmd;
        n = 0;
        forever begin
            @(negedge clk);
            if (mcl_yumi_o) break;
            n++;
            if (n > 200) begin
                vectors++; miscompares++;
                $display("FAIL accept_timeout: got no yumi expected yumi within 200 cycles");
                break;
            end
        end
        accept_cyc = cyc;
        @(posedge clk);
        #1;
        mcl_v_i = 1'b0;
        mcl_data_i = '0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0 && !mcl_v_o) break;
            n++;
            if (n > 300) begin
                vectors++; miscompares++;
                $display("FAIL resp_timeout: got %0d pending expected 0", exp_q.size());
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_v();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (mcl_v_o) break;
            n++;
            if (n > 100) begin
                vectors++; miscompares++;
                $display("FAIL v_timeout: got mcl_v_o 0 expected 1");
                break;
            end
        end
    endtask

    logic [79:0] e1;

    initial begin
        reset_i = 1'b1;
        mcl_v_i = 1'b1;
        mcl_data_i = {4'h1, 4'hF, 8'h00, 32'h0, 32'h0};
        mcl_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready,
                           mcl_v_o, mcl_yumi_o}, 0);
        chk("reset_data", mcl_data_o, 0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        mcl_v_i = 1'b0;
        mcl_data_i = '0;

        // Basic write, slave always ready
        issue({4'h1, 4'hF, 8'h5A, 32'h10, 32'hCAFEF00D},
              {4'h8, 2'b00, 2'b00, 8'h5A, 32'h10, 32'h0}, 1);
        wait_done();
        chk("wr_aw_latency", aw_hs_cyc - accept_cyc, 1);
        chk("wr_v_latency", v_rise_cyc - accept_cyc, 3);
        chk("wr_awaddr", seen_awaddr, 32'h10);
        chk("wr_wdata", seen_wdata, 32'hCAFEF00D);
        chk("wr_wstrb", seen_wstrb, 4'hF);

        // wready three cycles ahead of awready, EXOKAY bresp
        aw_wait = 3; b_resp_k = 2'b01; aw_only_cycles = 0;
        issue({4'h1, 4'h3, 8'h33, 32'h104, 32'h11223344},
              {4'h8, 2'b01, 2'b00, 8'h33, 32'h104, 32'h0}, 1);
        wait_done();
        chk("wr_aw_only_cycles", aw_only_cycles, 3);
        chk("wr2_awaddr", seen_awaddr, 32'h104);
        chk("wr2_wdata", seen_wdata, 32'h11223344);
        chk("wr2_wstrb", seen_wstrb, 4'h3);
        aw_wait = 0; b_resp_k = 2'b00;

        // Read with 5 wait cycles on r
        r_wait = 5; rd_data_k = 32'hDEADBEEF;
        issue({4'h2, 4'h0, 8'h01, 32'h24, 32'h0},
              {4'h9, 2'b00, 2'b00, 8'h01, 32'h24, 32'hDEADBEEF}, 1);
        wait_done();
        chk("rd_araddr", seen_araddr, 32'h24);

        // Minimum-latency read with SLVERR
        r_wait = 0; rd_data_k = 32'hA5A50F0F; r_resp_k = 2'b10;
        issue({4'h2, 4'h0, 8'h77, 32'h8, 32'h0},
              {4'h9, 2'b10, 2'b00, 8'h77, 32'h8, 32'hA5A50F0F}, 1);
        wait_done();
        chk("rd_ar_latency", ar_hs_cyc - accept_cyc, 1);
        chk("rd_v_latency", v_rise_cyc - accept_cyc, 3);
        r_resp_k = 2'b00;

        // Unknown op: no AXI traffic, SLVERR with op echoed
        any_valid_cycles = 0;
        issue({4'h7, 4'hF, 8'hC3, 32'h40, 32'h55},
              {4'h7, 2'b10, 2'b00, 8'hC3, 32'h40, 32'h0}, 1);
        wait_done();
        chk("badop_no_axi", any_valid_cycles, 0);

        // Response back-pressure for 10 cycles with a new command waiting
        mcl_ready_i = 1'b0;
        e1 = {4'h8, 2'b00, 2'b00, 8'h09, 32'h200, 32'h0};
        issue({4'h1, 4'hF, 8'h09, 32'h200, 32'h1}, e1, 1);
        wait_v();
        @(posedge clk);
        #1;
        rd_data_k = 32'h0BADF00D;
        exp_q.push_back({4'h9, 2'b00, 2'b00, 8'h0A, 32'h300, 32'h0BADF00D});
        mcl_v_i = 1'b1;
        mcl_data_i = {4'h2, 4'h0, 8'h0A, 32'h300, 32'h0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_v", mcl_v_o, 1);
            chk("stall_data", mcl_data_o, e1);
            chk("stall_yumi", mcl_yumi_o, 0);
        end
        @(posedge clk);
        #1;
        mcl_ready_i = 1'b1;
        issue({4'h2, 4'h0, 8'h0A, 32'h300, 32'h0}, '0, 0);
        chk("accept_after_hs", (accept_cyc - resp_hs_cyc) >= 1, 1);
        wait_done();

        // Read timeout, late beat swallowed, next command blocked until then
        r_hold = 1;
        issue({4'h2, 4'h0, 8'h66, 32'h500, 32'h0},
              {4'h9, 2'b11, 2'b00, 8'h66, 32'h500, 32'h0}, 1);
        wait_done();
        chk("timeout_latency", v_rise_cyc - ar_hs_cyc, 9);
        @(negedge clk);
        chk("drop_rready", axi.rready, 1);
        @(posedge clk);
        #1;
        mcl_v_i = 1'b1;
        mcl_data_i = {4'h1, 4'hF, 8'h67, 32'h600, 32'hABCD};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("drop_blocks_yumi", mcl_yumi_o, 0);
        end
        @(posedge clk);
        #1;
        rd_data_k = 32'h12345678;
        r_hold = 0;
        issue({4'h1, 4'hF, 8'h67, 32'h600, 32'hABCD},
              {4'h8, 2'b00, 2'b00, 8'h67, 32'h600, 32'h0}, 1);
        wait_done();
        @(negedge clk);
        chk("drop_cleared_rready", axi.rready, 0);
        @(posedge clk);
        #1;

        // Reset while waiting for b: abandoned, no response
        b_hold = 1;
        issue({4'h1, 4'hF, 8'h70, 32'h700, 32'h9}, '0, 0);
        for (int n = 0; n <= 20; n++) begin
            @(negedge clk);
            if (axi.bready) break;
            if (n == 20) begin
                vectors++; miscompares++;
                $display("FAIL bready_wait: got bready 0 expected 1");
            end
        end
        @(posedge clk);
        #1;
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        b_hold = 0;
        @(negedge clk);
        chk("midreset_outs", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready,
                              mcl_v_o}, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("midreset_no_resp", mcl_v_o, 0);
        end
        @(posedge clk);
        #1;
        rd_data_k = 32'hFEEDFACE;
        issue({4'h2, 4'h0, 8'h71, 32'h710, 32'h0},
              {4'h9, 2'b00, 2'b00, 8'h71, 32'h710, 32'hFEEDFACE}, 1);
        wait_done();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1, "watchdog");
    end

endmodule
